// File: rtl/snn_pkg.sv
// Shared constants and state encoding for the spike-frame scheduling path.
package snn_pkg;
  localparam int SYN_SW = 32;
  localparam int SYN_W  = 12;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, OUT} sched_state_t;

  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction
endpackage

// File: rtl/syn_sched_if.sv
// Bundle of the two frame sources, the synaptic unit link and the result port.
interface syn_sched_if #(
  parameter int N     = 256,
  parameter int TAG_W = 8
);
  import snn_pkg::*;

  logic                req0_valid;
  logic                req0_ready;
  logic [N-1:0]        req0_bits;
  logic                req1_valid;
  logic                req1_ready;
  logic [N-1:0]        req1_bits;
  logic [SYN_SW-1:0]   syn_sparse_bits;
  logic                syn_ipt_valid;
  logic                syn_ipt_ready;
  logic                syn_opt_valid;
  logic                syn_opt_ready;
  logic [SYN_W-1:0]    syn_opt_syn;
  logic                res_valid;
  logic                res_ready;
  logic [SYN_W-1:0]    res_syn;
  logic                res_src;
  logic [TAG_W-1:0]    res_tag;

  modport master (
    input  req0_valid, req0_bits, req1_valid, req1_bits,
           syn_ipt_ready, syn_opt_valid, syn_opt_syn, res_ready,
    output req0_ready, req1_ready, syn_sparse_bits, syn_ipt_valid,
           syn_opt_ready, res_valid, res_syn, res_src, res_tag
  );

  modport slave (
    output req0_valid, req0_bits, req1_valid, req1_bits,
           syn_ipt_ready, syn_opt_valid, syn_opt_syn, res_ready,
    input  req0_ready, req1_ready, syn_sparse_bits, syn_ipt_valid,
           syn_opt_ready, res_valid, res_syn, res_src, res_tag
  );
endinterface

// File: rtl/syn_sched_rr_arb2.sv
// Two-input round-robin arbiter; the grant doubles as the ready handshake.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && req[1]) gnt = last ? 2'b01 : 2'b10;
      else if (req[0])      gnt = 2'b01;
      else if (req[1])      gnt = 2'b10;
    end
  end

  // Any grant is a completed handshake, so the pointer moves on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= 1'b1;
    else if (|gnt)   last <= gnt[1];
  end
endmodule

// File: rtl/syn_sched.sv
// Shares one synaptic unit between two frame sources: accept, stream words, return tagged sum.
module syn_sched
  import snn_pkg::*;
#(
  parameter int N     = 256,
  parameter int TAG_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  syn_sched_if.master    bus
);
  localparam int WORDS = N / SYN_SW;
  localparam int CW    = cnt_width(WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

  sched_state_t      state;
  logic [N-1:0]      shift_reg;
  logic [CW-1:0]     cnt;
  logic              src;
  logic [TAG_W-1:0]  tag [2];
  logic              ipt_valid;
  logic              opt_ready;
  logic              res_valid;
  logic [SYN_W-1:0]  res_syn;
  logic              res_src;
  logic [TAG_W-1:0]  res_tag;
  logic [1:0]        gnt;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == IDLE),
    .req   ({bus.req1_valid, bus.req0_valid}),
    .gnt   (gnt)
  );

  assign bus.req0_ready      = gnt[0];
  assign bus.req1_ready      = gnt[1];
  assign bus.syn_sparse_bits = shift_reg[SYN_SW-1:0];
  assign bus.syn_ipt_valid   = ipt_valid;
  assign bus.syn_opt_ready   = opt_ready;
  assign bus.res_valid       = res_valid;
  assign bus.res_syn         = res_syn;
  assign bus.res_src         = res_src;
  assign bus.res_tag         = res_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      src       <= 1'b0;
      tag[0]    <= '0;
      tag[1]    <= '0;
      ipt_valid <= 1'b0;
      opt_ready <= 1'b0;
      res_valid <= 1'b0;
      res_syn   <= '0;
      res_src   <= 1'b0;
      res_tag   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            shift_reg <= gnt[1] ? bus.req1_bits : bus.req0_bits;
            src       <= gnt[1];
            cnt       <= '0;
            ipt_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // Zero words still go out: the synaptic unit counts words itself.
          if (bus.syn_ipt_ready) begin
            shift_reg <= shift_reg >> SYN_SW;
            cnt       <= cnt + 1'b1;
            if (cnt == LAST_WORD) begin
              ipt_valid <= 1'b0;
              opt_ready <= 1'b1;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.syn_opt_valid) begin
            res_syn   <= bus.syn_opt_syn;
            res_src   <= src;
            res_tag   <= tag[src];
            tag[src]  <= tag[src] + 1'b1;
            opt_ready <= 1'b0;
            res_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_syn_sched.sv
// Randomized bench for syn_sched with a frame-level reference model and a popcount synaptic stub.
module tb_syn_sched;
  import snn_pkg::*;

  localparam int N     = 256;
  localparam int TAG_W = 8;
  localparam int WORDS = N / SYN_SW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  syn_sched_if #(.N(N), .TAG_W(TAG_W)) bus ();
  syn_sched #(.N(N), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // sources
  int           to_send [2];
  logic         src_v   [2];
  logic [N-1:0] src_f   [2];
  int           kind;
  logic [N-1:0] pattern;
  int           ipt_pct, res_pct;

  // reference model
  logic         m_last;
  int           m_tag [2];
  bit           busy, have_res;
  int           m_src, m_words, m_sum, m_etag;
  logic [N-1:0] m_frame;

  // synaptic stub
  int stub_words, stub_acc;
  bit stub_pend, stub_ov;

  logic [SYN_SW-1:0] word_log [$];
  int grant_log [$];
  int res_syn_log [$];
  int res_src_log [$];
  int res_tag_log [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [N-1:0] make_frame();
    logic [N-1:0] f;
    if (kind == 1) return '0;
    if (kind == 2) return pattern;
    for (int i = 0; i < WORDS; i++) f[i*SYN_SW +: SYN_SW] = $urandom;
    if ($urandom_range(0, 2) == 0)
      for (int i = 0; i < WORDS; i++) f[i*SYN_SW +: SYN_SW] &= $urandom;
    return f;
  endfunction

  task automatic check_reset_outputs(input string tg);
    chk({tg, "_req0_ready"}, bus.req0_ready, 0);
    chk({tg, "_req1_ready"}, bus.req1_ready, 0);
    chk({tg, "_ipt_valid"},  bus.syn_ipt_valid, 0);
    chk({tg, "_word"},       bus.syn_sparse_bits, 0);
    chk({tg, "_opt_ready"},  bus.syn_opt_ready, 0);
    chk({tg, "_res_valid"},  bus.res_valid, 0);
    chk({tg, "_res_syn"},    bus.res_syn, 0);
    chk({tg, "_res_src"},    bus.res_src, 0);
    chk({tg, "_res_tag"},    bus.res_tag, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_bits = '0; bus.req1_bits = '0;
    bus.syn_ipt_ready = 0; bus.syn_opt_valid = 0; bus.syn_opt_syn = '0; bus.res_ready = 0;
    src_v = '{1'b0, 1'b0}; to_send = '{0, 0};
    m_last = 1'b1; m_tag = '{0, 0}; busy = 0; have_res = 0; m_words = 0;
    stub_words = 0; stub_acc = 0; stub_pend = 0; stub_ov = 0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive at the falling edge, sample 1 time unit later, advance the model.
  task automatic step();
    logic [1:0] v, rdy, exp_rdy;
    bit was_busy, hs_ipt, hs_opt, hs_res;
    int s;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      if (!src_v[i] && to_send[i] > 0) begin src_v[i] = 1'b1; src_f[i] = make_frame(); end
    bus.req0_valid = src_v[0]; bus.req0_bits = src_f[0];
    bus.req1_valid = src_v[1]; bus.req1_bits = src_f[1];
    bus.syn_ipt_ready = ($urandom_range(1, 100) <= ipt_pct);
    bus.res_ready     = ($urandom_range(1, 100) <= res_pct);
    if (stub_pend) begin
      if (!stub_ov) stub_ov = ($urandom_range(0, 3) != 0);
      bus.syn_opt_valid = stub_ov;
      bus.syn_opt_syn   = stub_ov ? stub_acc[SYN_W-1:0] : SYN_W'($urandom);
    end else begin
      bus.syn_opt_valid = ($urandom_range(0, 9) == 0);
      bus.syn_opt_syn   = SYN_W'($urandom);
    end
    #1;
    v   = {bus.req1_valid, bus.req0_valid};
    rdy = {bus.req1_ready, bus.req0_ready};
    exp_rdy = 2'b00;
    if (!busy) exp_rdy = (v == 2'b11) ? (m_last ? 2'b01 : 2'b10) : v;
    chk("req_ready", rdy, exp_rdy);
    chk("ipt_valid", bus.syn_ipt_valid, busy && m_words < WORDS);
    chk("opt_ready", bus.syn_opt_ready, busy && m_words == WORDS && !have_res);
    chk("res_valid", bus.res_valid, have_res);
    if (bus.syn_ipt_valid && busy && m_words < WORDS)
      chk("word", bus.syn_sparse_bits, m_frame[m_words*SYN_SW +: SYN_SW]);
    if (have_res) begin
      chk("res_syn", bus.res_syn, m_sum);
      chk("res_src", bus.res_src, m_src);
      chk("res_tag", bus.res_tag, m_etag);
    end
    was_busy = busy;
    hs_ipt = bus.syn_ipt_valid && bus.syn_ipt_ready;
    hs_opt = bus.syn_opt_valid && bus.syn_opt_ready;
    hs_res = bus.res_valid && bus.res_ready;
    if (hs_res) begin
      res_syn_log.push_back(int'(bus.res_syn));
      res_src_log.push_back(int'(bus.res_src));
      res_tag_log.push_back(int'(bus.res_tag));
      have_res = 0; busy = 0;
    end
    if (hs_opt) begin
      chk("words_per_frame", stub_words, WORDS);
      have_res = 1; stub_pend = 0; stub_ov = 0; stub_words = 0; stub_acc = 0;
    end
    if (hs_ipt) begin
      word_log.push_back(bus.syn_sparse_bits);
      stub_acc += $countones(bus.syn_sparse_bits);
      stub_words++;
      if (stub_words == WORDS) stub_pend = 1;
      if (busy) m_words++;
    end
    if (|(v & rdy)) begin
      s = (v[1] && rdy[1] && !(v[0] && rdy[0])) ? 1 : 0;
      src_v[s] = 1'b0;
      to_send[s]--;
      if (!was_busy) begin
        m_last = s[0]; busy = 1; m_words = 0; m_src = s;
        m_frame = src_f[s]; m_sum = $countones(src_f[s]);
        m_etag = m_tag[s]; m_tag[s] = (m_tag[s] + 1) % (1 << TAG_W);
        grant_log.push_back(s);
      end
    end
  endtask

  task automatic run(input int n0, input int n1, input int k, input int ip, input int rp,
                     input int budget);
    int c = 0;
    to_send = '{n0, n1}; kind = k; ipt_pct = ip; res_pct = rp;
    word_log.delete(); grant_log.delete();
    res_syn_log.delete(); res_src_log.delete(); res_tag_log.delete();
    while (res_syn_log.size() < n0 + n1 && c < budget) begin step(); c++; end
    chk("frames_done", res_syn_log.size(), n0 + n1);
  endtask

  initial begin
    logic [SYN_SW-1:0] exp_w [WORDS];
    int bits [16];
    int c;
    bits  = '{9, 12, 22, 26, 30, 41, 44, 53, 55, 59, 62, 63, 68, 76, 79, 80};
    exp_w = '{32'h44401200, 32'hC8A01200, 32'h00019010, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    ipt_pct = 100; res_pct = 100; kind = 0; pattern = '0;

    // single hand-checked frame
    do_reset();
    foreach (bits[i]) pattern[bits[i]] = 1'b1;
    run(1, 0, 2, 100, 100, 200);
    chk("single_nwords", word_log.size(), WORDS);
    for (int i = 0; i < word_log.size() && i < WORDS; i++) chk("single_word", word_log[i], exp_w[i]);
    if (res_syn_log.size() == 1) begin
      chk("single_syn", res_syn_log[0], 16);
      chk("single_src", res_src_log[0], 0);
      chk("single_tag", res_tag_log[0], 0);
    end

    // contention from reset
    do_reset();
    run(2, 2, 0, 100, 100, 400);
    if (grant_log.size() == 4) begin
      chk("cont_g0", grant_log[0], 0); chk("cont_g1", grant_log[1], 1);
      chk("cont_g2", grant_log[2], 0); chk("cont_g3", grant_log[3], 1);
    end
    if (res_tag_log.size() == 4) begin
      chk("cont_t0", res_tag_log[0], 0); chk("cont_t1", res_tag_log[1], 0);
      chk("cont_t2", res_tag_log[2], 1); chk("cont_t3", res_tag_log[3], 1);
    end
    run(1, 0, 0, 100, 100, 200);
    if (res_tag_log.size() == 1) chk("cont_tag0_next", res_tag_log[0], 2);
    run(0, 1, 0, 100, 100, 200);
    if (res_tag_log.size() == 1) chk("cont_tag1_next", res_tag_log[0], 2);

    // backpressure on both sides
    run(20, 20, 0, 80, 80, 4000);
    chk("bp_nwords", word_log.size(), 40 * WORDS);

    // zero frames
    do_reset();
    run(2, 0, 1, 90, 90, 400);
    chk("zero_nwords", word_log.size(), 2 * WORDS);
    if (res_syn_log.size() == 2) begin
      chk("zero_syn0", res_syn_log[0], 0); chk("zero_syn1", res_syn_log[1], 0);
      chk("zero_tag0", res_tag_log[0], 0); chk("zero_tag1", res_tag_log[1], 1);
    end

    // tag wrap on source 1
    do_reset();
    run(0, 257, 0, 100, 100, 8000);
    if (res_tag_log.size() == 257) begin
      chk("wrap_tag255", res_tag_log[255], 255);
      chk("wrap_tag256", res_tag_log[256], 0);
      chk("wrap_src", res_src_log[256], 1);
    end

    // reset in the middle of a frame
    do_reset();
    to_send = '{1, 0}; kind = 0; ipt_pct = 70; res_pct = 100;
    c = 0;
    while (m_words < 3 && c < 200) begin step(); c++; end
    chk("midrst_reached_word3", m_words, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    do_reset();
    run(1, 0, 0, 100, 100, 200);
    if (res_tag_log.size() == 1) begin
      chk("midrst_tag", res_tag_log[0], 0);
      chk("midrst_src", res_src_log[0], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
